// File: rtl/mips_codes_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, states,
// datapath select codes and the bundled control-word payload.
package mips_codes;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    // Top three opcode bits that mark a load (100xxx).
    localparam logic [2:0] OP_LOAD_HI = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_FUNCT = 3'b010,
        ALU_SUB   = 3'b110,
        ALU_NOP   = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RS     = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'b00,
        M2R_MDR    = 2'b01,
        M2R_PC     = 2'b10
    } mem2reg_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [2:0] {
        DC_RTYPE  = 3'd0,
        DC_JR     = 3'd1,
        DC_MEM    = 3'd2,
        DC_BRANCH = 3'd3,
        DC_JUMP   = 3'd4,
        DC_JAL    = 3'd5,
        DC_ADDI   = 3'd6,
        DC_TRAP   = 3'd7
    } dec_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       sign_xtend;
        logic       illegal;
        pc_src_t    pc_src;
        reg_dst_t   reg_dst;
        mem2reg_t   mem2reg;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Instruction classifier: maps opcode/funct to the state class taken out of DECODE.
module ctrl_decode
    import mips_codes::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_class_t dec_class
);

    always_comb begin
        dec_class = DC_TRAP;
        casez (opcode)
            OP_RTYPE:   dec_class = (funct == FN_JR) ? DC_JR : DC_RTYPE;
            6'b100???:  dec_class = DC_MEM;
            6'b1010??:  dec_class = DC_MEM;
            OP_BEQ:     dec_class = DC_BRANCH;
            OP_BNE:     dec_class = DC_BRANCH;
            OP_J:       dec_class = DC_JUMP;
            OP_JAL:     dec_class = DC_JAL;
            OP_ADDI:    dec_class = DC_ADDI;
            default:    dec_class = DC_TRAP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM. Outputs decode from the current state (plus
// mem_ready/zero where the datapath needs same-cycle response) and are forced low in reset.
module multicycle_ctrl
    import mips_codes::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       sign_xtend,
    output logic       illegal,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem2reg,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       r_is_bne;
    dec_class_t w_class;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;

    ctrl_decode u_decode (
        .opcode    (opcode),
        .funct     (funct),
        .dec_class (w_class)
    );

    // Branch flavour is captured in DECODE so opcode is ignored once in BRANCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_is_bne <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_bne <= (opcode == OP_BNE);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ctrl        = '0;
        w_ctrl.alu_op = ALU_NOP;
        unique case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.pc_src    = PC_ALU;
                w_ctrl.pc_write  = mem_ready;
                w_ctrl.ir_write  = mem_ready;
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_b  = SRCB_IMM_SH;
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.sign_xtend = 1'b1;
                unique case (w_class)
                    DC_RTYPE:  w_next = S_EXEC_R;
                    DC_JR:     w_next = S_JR;
                    DC_MEM:    w_next = S_MEM_ADDR;
                    DC_BRANCH: w_next = S_BRANCH;
                    DC_JUMP:   w_next = S_JUMP;
                    DC_JAL:    w_next = S_JAL;
                    DC_ADDI:   w_next = S_EXEC_I;
                    default:   w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.sign_xtend = 1'b1;
                w_next = (opcode[5:3] == OP_LOAD_HI) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = RD_RT;
                w_ctrl.mem2reg   = M2R_MDR;
                w_next           = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_next           = S_R_WB;
            end
            S_R_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = RD_RD;
                w_ctrl.mem2reg   = M2R_ALUOUT;
                w_next           = S_FETCH;
            end
            S_EXEC_I: begin
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = SRCB_IMM;
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.sign_xtend = 1'b1;
                w_next            = S_I_WB;
            end
            S_I_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = RD_RT;
                w_ctrl.mem2reg   = M2R_ALUOUT;
                w_next           = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = PC_ALUOUT;
                w_ctrl.pc_write  = r_is_bne ? ~zero : zero;
                w_next           = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PC_JUMP;
                w_next          = S_FETCH;
            end
            S_JAL: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_src    = PC_JUMP;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = RD_RA;
                w_ctrl.mem2reg   = M2R_PC;
                w_next           = S_FETCH;
            end
            S_JR: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PC_RS;
                w_next          = S_FETCH;
            end
            S_TRAP: begin
                // Sticky: everything quiet except the illegal flag.
                w_ctrl         = '0;
                w_ctrl.illegal = 1'b1;
                w_next         = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign w_out = rst ? '0 : w_ctrl;

    assign pc_write   = w_out.pc_write;
    assign ir_write   = w_out.ir_write;
    assign iord       = w_out.iord;
    assign mem_read   = w_out.mem_read;
    assign mem_write  = w_out.mem_write;
    assign reg_write  = w_out.reg_write;
    assign alu_src_a  = w_out.alu_src_a;
    assign sign_xtend = w_out.sign_xtend;
    assign illegal    = w_out.illegal;
    assign pc_src     = w_out.pc_src;
    assign reg_dst    = w_out.reg_dst;
    assign mem2reg    = w_out.mem2reg;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_op     = w_out.alu_op;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues a hand-built expected
// control word per cycle, a negedge monitor pops and compares it.
module tb_multicycle_ctrl;

    // {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a,
    //  sign_xtend, illegal, pc_src, reg_dst, mem2reg, alu_src_b, alu_op, state}
    localparam logic [23:0] E_ZERO     = 24'h000000;
    localparam logic [23:0] E_FETCH    = {9'b110100000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 4'd0};
    localparam logic [23:0] E_FETCH_W  = {9'b000100000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 4'd0};
    localparam logic [23:0] E_DECODE   = {9'b000000010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 4'd1};
    localparam logic [23:0] E_MEM_ADDR = {9'b000000110, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 4'd2};
    localparam logic [23:0] E_MEM_RD   = {9'b001100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 4'd3};
    localparam logic [23:0] E_MEM_WB   = {9'b000001000, 2'b00, 2'b00, 2'b01, 2'b00, 3'b111, 4'd4};
    localparam logic [23:0] E_MEM_WR   = {9'b001010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 4'd5};
    localparam logic [23:0] E_EXEC_R   = {9'b000000100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 4'd6};
    localparam logic [23:0] E_R_WB     = {9'b000001000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b111, 4'd7};
    localparam logic [23:0] E_EXEC_I   = {9'b000000110, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 4'd8};
    localparam logic [23:0] E_I_WB     = {9'b000001000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 4'd9};
    localparam logic [23:0] E_BR_T     = {9'b100000100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b110, 4'd10};
    localparam logic [23:0] E_BR_NT    = {9'b000000100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b110, 4'd10};
    localparam logic [23:0] E_JUMP     = {9'b100000000, 2'b10, 2'b00, 2'b00, 2'b00, 3'b111, 4'd11};
    localparam logic [23:0] E_JAL      = {9'b100001000, 2'b10, 2'b10, 2'b10, 2'b00, 3'b111, 4'd12};
    localparam logic [23:0] E_JR       = {9'b100000000, 2'b11, 2'b00, 2'b00, 2'b00, 3'b111, 4'd13};
    localparam logic [23:0] E_TRAP     = {9'b000000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 4'd14};

    typedef struct {
        logic [23:0] v;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, alu_src_a, sign_xtend, illegal;
    logic [1:0] pc_src, reg_dst, mem2reg, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .sign_xtend (sign_xtend),
        .illegal    (illegal),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state_o    (state_o)
    );

    // Monitor: mid-cycle sample of the full control word against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [23:0] act;
            e   = q.pop_front();
            act = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a,
                   sign_xtend, illegal, pc_src, reg_dst, mem2reg, alu_src_b, alu_op, state_o};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %06h expected %06h", e.nm, act, e.v);
            end
        end
    end

    task automatic cyc(input logic [23:0] v, input string nm);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(E_ZERO, "reset_outputs");
        rst = 1'b0;

        // ADD; opcode/funct garbage in EXEC_R must be ignored
        opcode = 6'b000000; funct = 6'b100000;
        cyc(E_FETCH,  "add_fetch");
        cyc(E_DECODE, "add_decode");
        opcode = 6'b111111; funct = 6'b001000;
        cyc(E_EXEC_R, "add_exec");
        cyc(E_R_WB,   "add_wb");

        // ADDI with one fetch wait
        opcode = 6'b001000; mem_ready = 1'b0;
        cyc(E_FETCH_W, "addi_fetch_wait");
        mem_ready = 1'b1;
        cyc(E_FETCH,   "addi_fetch");
        cyc(E_DECODE,  "addi_decode");
        cyc(E_EXEC_I,  "addi_exec");
        cyc(E_I_WB,    "addi_wb");

        // LW with two read wait cycles; MEM_WB lands in cycle 7
        opcode = 6'b100011;
        cyc(E_FETCH,    "lw_fetch");
        cyc(E_DECODE,   "lw_decode");
        cyc(E_MEM_ADDR, "lw_addr");
        mem_ready = 1'b0; opcode = 6'b101011;
        cyc(E_MEM_RD,   "lw_rd_wait1");
        cyc(E_MEM_RD,   "lw_rd_wait2");
        mem_ready = 1'b1;
        cyc(E_MEM_RD,   "lw_rd_done");
        cyc(E_MEM_WB,   "lw_wb");

        // SW, no waits
        opcode = 6'b101011;
        cyc(E_FETCH,    "sw_fetch");
        cyc(E_DECODE,   "sw_decode");
        cyc(E_MEM_ADDR, "sw_addr");
        cyc(E_MEM_WR,   "sw_wr");

        // BEQ not taken; opcode flipped to BNE inside BRANCH must not matter
        opcode = 6'b000100; zero = 1'b0;
        cyc(E_FETCH,  "beq0_fetch");
        cyc(E_DECODE, "beq0_decode");
        opcode = 6'b000101;
        cyc(E_BR_NT,  "beq_zero0");

        opcode = 6'b000100; zero = 1'b1;
        cyc(E_FETCH,  "beq1_fetch");
        cyc(E_DECODE, "beq1_decode");
        cyc(E_BR_T,   "beq_zero1");

        opcode = 6'b000101; zero = 1'b0;
        cyc(E_FETCH,  "bne0_fetch");
        cyc(E_DECODE, "bne0_decode");
        cyc(E_BR_T,   "bne_zero0");

        opcode = 6'b000101; zero = 1'b1;
        cyc(E_FETCH,  "bne1_fetch");
        cyc(E_DECODE, "bne1_decode");
        cyc(E_BR_NT,  "bne_zero1");
        zero = 1'b0;

        opcode = 6'b000010;
        cyc(E_FETCH,  "j_fetch");
        cyc(E_DECODE, "j_decode");
        cyc(E_JUMP,   "j_jump");

        opcode = 6'b000011;
        cyc(E_FETCH,  "jal_fetch");
        cyc(E_DECODE, "jal_decode");
        cyc(E_JAL,    "jal_link");
        cyc(E_FETCH,  "jal_next_fetch");

        opcode = 6'b000000; funct = 6'b001000;
        cyc(E_DECODE, "jr_decode");
        cyc(E_JR,     "jr_jump");

        // SB stalled in MEM_WR, then reset mid-wait
        opcode = 6'b101000; funct = 6'b000000;
        cyc(E_FETCH,    "sb_fetch");
        cyc(E_DECODE,   "sb_decode");
        cyc(E_MEM_ADDR, "sb_addr");
        mem_ready = 1'b0;
        cyc(E_MEM_WR,   "sb_wr_wait");
        rst = 1'b1;
        cyc(E_ZERO,     "sb_rst_same_cycle");
        cyc(E_ZERO,     "sb_rst_hold");
        rst = 1'b0; mem_ready = 1'b1;

        // Illegal opcode traps and stays trapped regardless of inputs
        opcode = 6'b111111;
        cyc(E_FETCH,  "trap_fetch");
        cyc(E_DECODE, "trap_decode");
        for (int i = 0; i < 10; i++) begin
            opcode    = 6'(i);
            mem_ready = i[0];
            cyc(E_TRAP, "trap_hold");
        end
        rst = 1'b1;
        cyc(E_ZERO, "trap_rst");
        rst = 1'b0; mem_ready = 1'b1; opcode = 6'b001000;
        cyc(E_FETCH,  "post_trap_fetch");
        cyc(E_DECODE, "post_trap_decode");

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  instruction register bits [31:26].
REQ-005 funct  in  6  instruction register bits [5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-008 Single-bit outputs SHALL be: pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a, sign_xtend, illegal.
REQ-009 Multi-bit outputs SHALL be:
- pc_src[1:0]: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- reg_dst[1:0]: 00 rt, 01 rd, 10 $31.
- mem2reg[1:0]: 00 ALUOut, 01 MDR, 10 PC.
- alu_src_b[1:0]: 00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- alu_op[2:0]: 000 ADD, 110 SUB, 010 FUNCT, 111 NOP.
- state_o[3:0]: current state.

Function
REQ-010 States SHALL be FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, TRAP.
REQ-011 FETCH outputs:
- mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
- pc_write and ir_write SHALL equal mem_ready.
- FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-012 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD, sign_xtend=1.
REQ-013 DECODE SHALL branch on opcode:
- 000000 with funct 001000 -> JR.
- 000000 with any other funct -> EXEC_R.
- 100xxx -> MEM_ADDR.
- 1010xx -> MEM_ADDR.
- 000100 or 000101 -> BRANCH.
- 000010 -> JUMP.
- 000011 -> JAL.
- 001000 -> EXEC_I.
- any other opcode -> TRAP.
REQ-014 MEM_ADDR outputs: alu_src_a=1, alu_src_b=10, alu_op=ADD, sign_xtend=1.
REQ-015 MEM_ADDR SHALL go to MEM_RD when opcode[5:3]=100, otherwise to MEM_WR.
REQ-016 MEM_RD: mem_read=1, iord=1; SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-017 MEM_WR: mem_write=1, iord=1; SHALL hold until mem_ready=1, then go to FETCH.
REQ-018 Handshake: mem_read/mem_write SHALL stay asserted, with iord stable, every cycle until mem_ready=1, and SHALL never be asserted together.
REQ-019 MEM_WB: reg_write=1, reg_dst=00, mem2reg=01; next state FETCH.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT; next state R_WB.
REQ-021 R_WB: reg_write=1, reg_dst=01, mem2reg=00; next state FETCH.
REQ-022 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD, sign_xtend=1; next state I_WB.
REQ-023 I_WB: reg_write=1, reg_dst=00, mem2reg=00; next state FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01; next state FETCH.
REQ-025 In BRANCH, pc_write SHALL equal zero for opcode 000100 (BEQ) and SHALL equal !zero for opcode 000101 (BNE).
REQ-026 JUMP: pc_write=1, pc_src=10; next state FETCH.
REQ-027 JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem2reg=10; next state FETCH.
REQ-028 JR: pc_write=1, pc_src=11; next state FETCH.
REQ-029 TRAP: illegal=1 and all other outputs 0; TRAP SHALL be left only by reset.
REQ-030 Outputs not listed for a state SHALL be 0. alu_op SHALL be NOP where not listed.
REQ-031 Latency with mem_ready=1 on every memory cycle: R-type 4, ADDI 4, load 5, store 4, branch 3, J/JAL/JR 3 cycles.
REQ-032 Each memory wait cycle SHALL add exactly one cycle to that latency.
REQ-033 opcode and funct SHALL be sampled only in DECODE and MEM_ADDR; changes in any other state SHALL have no effect.

Reset
REQ-034 While rst=1, state SHALL be FETCH and every output SHALL be 0, including illegal and memory strobes.
REQ-035 Reset asserted mid-operation, including during a memory wait, SHALL abandon the instruction immediately.
REQ-036 After rst is released, the first cycle SHALL be FETCH with mem_read=1.

Structure
REQ-037 Package mips_codes SHALL hold the opcode and funct constants, the state enum, and the alu_op, pc_src, reg_dst, mem2reg and alu_src_b encodings.
REQ-038 A combinational sub-module ctrl_decode SHALL map opcode/funct to the DECODE next-state class. The FSM SHALL reside in multicycle_ctrl.

Verification
REQ-039 ADD (opcode 000000, funct 100000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB; reg_write=1 with reg_dst=01 in cycle 4.
REQ-040 LW (opcode 100011), mem_ready low 2 cycles in MEM_RD -> mem_read held 3 cycles, iord=1; MEM_WB in cycle 7.
REQ-041 BEQ with zero=0 -> pc_write=0 in BRANCH; BNE with zero=0 -> pc_write=1, pc_src=01.
REQ-042 JAL (opcode 000011) -> one cycle with reg_write=1, reg_dst=10, mem2reg=10, pc_src=10; next FETCH.
REQ-043 Opcode 111111 -> TRAP, illegal=1 held for 10 cycles; rst pulse -> illegal=0, state FETCH.
REQ-044 rst asserted in MEM_WR wait -> mem_write=0 in the same cycle; FETCH after release.
